// File: rtl/seg7_pkg.sv
// Shared glyph constants, widths and scan states for the multiplexed
// seven-segment driver. Segment order is g..a with bit 0 = a, high-true.
package seg7_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
   localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
   localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
   localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
   localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   typedef enum logic {
      ST_OFF  = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

   // Counter width that stays at least one bit wide for tiny ranges.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational nibble-to-glyph decode, high-true. Codes 10..15 show
// hex letters only when hex_en is set, otherwise they decode to blank.
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [3:0]       code,
   input  logic             hex_en,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = hex_en ? SEG_A : SEG_BLANK;
         4'hB: seg = hex_en ? SEG_B : SEG_BLANK;
         4'hC: seg = hex_en ? SEG_C : SEG_BLANK;
         4'hD: seg = hex_en ? SEG_D : SEG_BLANK;
         4'hE: seg = hex_en ? SEG_E : SEG_BLANK;
         4'hF: seg = hex_en ? SEG_F : SEG_BLANK;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-aligned double buffering,
// leading-zero blanking and registered, polarity-selectable pin outputs.
//
// state   | meaning
// ST_OFF  | enable low: all digits dark, prescaler and digit index held
// ST_SCAN | enable high: prescaler running, one digit lit at a time
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int HEX_MODE    = 0,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int PW = cnt_w(REFRESH_DIV);
   localparam int IW = cnt_w(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic          POL        = (ACTIVE_LOW != 0);

   scan_state_e state_q, state_d;
   logic        run;

   // Down-counter of cycles left on the current digit; PRESC_LAST means a
   // digit has just started (elapsed count zero).
   logic [PW-1:0] presc_left;
   logic [IW-1:0] idx;
   logic          digit_done, frame_end;

   logic [4*NUM_DIGITS-1:0] sh_dig, act_dig;
   logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
   logic                    sh_blz, act_blz, act_vld, pending;

   logic [3:0]            cur_code;
   logic                  cur_dp;
   logic                  lz_blank, zero_run;
   logic [NUM_DIGITS-1:0] zero_from;
   logic [SEG_W-1:0]      rom_seg, seg_hi;
   logic [NUM_DIGITS-1:0] an_hi;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_OFF;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      run     = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (enable) begin
               state_d = ST_SCAN;
               run     = 1'b1;
            end
         end
         ST_SCAN: begin
            if (enable) run = 1'b1;
            else        state_d = ST_OFF;
         end
         default: state_d = ST_OFF;
      endcase
   end

   assign digit_done = run && (presc_left == '0);
   assign frame_end  = digit_done && (idx == IDX_LAST);
   assign frame_tick = frame_end;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_left <= PRESC_LAST;
         idx        <= '0;
      end else if (run) begin
         if (presc_left == '0) begin
            presc_left <= PRESC_LAST;
            idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            presc_left <= presc_left - 1'b1;
         end
      end
   end

   // Shadow captures every load; active only changes on the frame wrap, so
   // a frame is never drawn from two different data sets.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_dig  <= '0;
         sh_dp   <= '0;
         sh_blz  <= 1'b0;
         act_dig <= '0;
         act_dp  <= '0;
         act_blz <= 1'b0;
         act_vld <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (frame_end && pending) begin
            act_dig <= sh_dig;
            act_dp  <= sh_dp;
            act_blz <= sh_blz;
            act_vld <= 1'b1;
         end
         if (load) begin
            sh_dig  <= digits_in;
            sh_dp   <= dp_in;
            sh_blz  <= blank_lz;
            pending <= 1'b1;
         end else if (frame_end) begin
            pending <= 1'b0;
         end
      end
   end

   always_comb begin
      cur_code  = act_dig[{idx, 2'b00} +: 4];
      cur_dp    = act_dp[idx];
      zero_run  = 1'b1;
      zero_from = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run     = zero_run & (act_dig[4*k +: 4] == 4'h0);
         zero_from[k] = zero_run;
      end
      lz_blank = act_blz && (idx != '0) && zero_from[idx];
      seg_hi   = lz_blank ? SEG_BLANK : rom_seg;
      an_hi    = '0;
      an_hi[idx] = 1'b1;
   end

   seg7_glyph_rom u_rom (
      .code   (cur_code),
      .hex_en (HEX_MODE != 0),
      .seg    (rom_seg)
   );

   // Polarity is applied only here; everything upstream is high-true.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg <= {SEG_W{POL}};
         dp  <= POL;
         an  <= {NUM_DIGITS{POL}};
      end else if (run && act_vld) begin
         seg <= seg_hi ^ {SEG_W{POL}};
         dp  <= cur_dp ^ POL;
         an  <= an_hi ^ {NUM_DIGITS{POL}};
      end else begin
         seg <= {SEG_W{POL}};
         dp  <= POL;
         an  <= {NUM_DIGITS{POL}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (letters blank / hex letters)
// checked every cycle against a frame-position reference model.
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int R  = 4;
   localparam int FR = N * R;

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic           load = 1'b0;
   logic [4*N-1:0] digits_in = '0;
   logic [N-1:0]   dp_in = '0;
   logic           blank_lz = 1'b0;

   logic [6:0]   seg0, seg1;
   logic         dp0, dp1, ft0, ft1;
   logic [N-1:0] an0, an1;

   int checks = 0;
   int errors = 0;

   // reference model: position within the frame plus buffered data
   int          pos;
   logic [15:0] a_dig, s_dig;
   logic [3:0]  a_dp, s_dp;
   logic        a_blz, s_blz, a_vld, pend;
   logic [6:0]  e_seg0, e_seg1;
   logic        e_dp;
   logic [3:0]  e_an;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0));

   seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1), .ACTIVE_LOW(1)) dut_hex (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1));

   function automatic logic [6:0] glyph(input int code, input bit hex);
      return (code < 10 || hex) ? GLYPH[code] : 7'h00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h (pos %0d)", tag, got, exp, pos);
      end
   endtask

   task automatic step();
      bit fr, blank;
      int d;
      @(posedge clk);
      if (!rst_n) begin
         pos = 0;
         a_dig = '0; a_dp = '0; a_blz = 1'b0; a_vld = 1'b0;
         s_dig = '0; s_dp = '0; s_blz = 1'b0; pend = 1'b0;
         e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end else begin
         fr = enable && (pos == FR - 1);
         if (enable && a_vld) begin
            d = pos / R;
            blank = a_blz && (d != 0) && ((a_dig >> (4 * d)) == 16'h0);
            e_seg0 = ~(blank ? 7'h00 : glyph(int'(a_dig[4*d +: 4]), 1'b0));
            e_seg1 = ~(blank ? 7'h00 : glyph(int'(a_dig[4*d +: 4]), 1'b1));
            e_dp   = ~a_dp[d];
            e_an   = ~(4'b0001 << d);
         end else begin
            e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
         end
         if (enable) pos = (pos + 1) % FR;
         if (fr && pend) begin
            a_dig = s_dig; a_dp = s_dp; a_blz = s_blz; a_vld = 1'b1;
         end
         if (load) begin
            s_dig = digits_in; s_dp = dp_in; s_blz = blank_lz; pend = 1'b1;
         end else if (fr) begin
            pend = 1'b0;
         end
      end
      #1;
      chk("an",      32'(an0),  32'(e_an));
      chk("seg",     32'(seg0), 32'(e_seg0));
      chk("dp",      32'(dp0),  32'(e_dp));
      chk("tick",    32'(ft0),  32'(enable && (pos == FR - 1)));
      chk("an_hex",  32'(an1),  32'(e_an));
      chk("seg_hex", 32'(seg1), 32'(e_seg1));
      chk("dp_hex",  32'(dp1),  32'(e_dp));
      chk("tick_hex", 32'(ft1), 32'(enable && (pos == FR - 1)));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [15:0] dig, input logic [3:0] dps, input logic blz);
      digits_in = dig; dp_in = dps; blank_lz = blz; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic goto_pos(input int target);
      for (int i = 0; i < FR && pos != target; i++) step();
   endtask

   initial begin
      logic [31:0] r;
      // reset state
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;

      // basic scan of 1234
      enable = 1'b1;
      do_load(16'h1234, 4'b0000, 1'b0);
      run(3 * FR);

      // leading-zero blanking, including an all-zero value
      do_load(16'h0070, 4'b0100, 1'b1);
      run(2 * FR);
      do_load(16'h0000, 4'b0000, 1'b1);
      run(2 * FR);

      // hex letters vs blank on the two instances
      do_load(16'h00AF, 4'b0001, 1'b0);
      run(2 * FR);

      // last load wins, current frame untouched
      goto_pos(5);
      do_load(16'h1111, 4'b0000, 1'b0);
      step();
      do_load(16'h2222, 4'b1010, 1'b0);
      run(2 * FR);

      // load on the frame_tick cycle
      goto_pos(6);
      do_load(16'h5678, 4'b0011, 1'b0);
      goto_pos(FR - 1);
      do_load(16'h9ABC, 4'b1100, 1'b0);
      run(2 * FR);

      // enable drop mid-frame resumes from the held position
      goto_pos(7);
      enable = 1'b0;
      run(10);
      enable = 1'b1;
      run(FR + 3);

      // reset during digit 2 discards everything
      do_load(16'h4321, 4'b0000, 1'b0);
      goto_pos(9);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      run(FR + 2);
      do_load(16'h8765, 4'b1001, 1'b0);
      run(2 * FR);

      // randomized traffic
      for (int i = 0; i < 900; i++) begin
         r = $urandom;
         load = (r[26:24] == 3'd0);
         if (load) begin
            digits_in = r[15:0] >> (4 * r[17:16]);
            dp_in     = r[21:18];
            blank_lz  = r[22];
         end
         if ($urandom_range(0, 24) == 0) enable = ~enable;
         rst_n = ($urandom_range(0, 399) != 0);
         step();
      end
      load = 1'b0;
      rst_n = 1'b1;
      enable = 1'b1;
      run(2 * FR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
